key_bounce_gen: RTL and testbench
=================================

KEY_BOUNCE_GEN -- requirements
Module: key_bounce_gen

Interface
REQ-001 Parameter CLK_FREQ_MHZ, default 100, clock frequency in MHz.
REQ-002 Parameter GLITCH_TIME_NS, default 150, debounce glitch window in ns; GLITCH_TIME_CYCLES = ceil(CLK_FREQ_MHZ*GLITCH_TIME_NS/1000), 15 at defaults.
REQ-003 Parameter BOUNCE_CYCLES, default 20, length in cycles of each bounce phase, range 1 to 255.
REQ-004 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value, nonzero.
REQ-005 clk_i  input  1  single clock; all logic on posedge.
REQ-006 rst_n_i  input  1  asynchronous, active-low reset.
REQ-007 press_req_i  input  1  request one emulated key press.
REQ-008 press_len_i  input  16  stable-low hold length in cycles, sampled on acceptance.
REQ-009 ready_o  output  1  high when idle and able to accept a request.
REQ-010 key_o  output  1  emulated key line, active-low (1 = released).
REQ-011 done_stb_o  output  1  one-cycle pulse when a press sequence completes.

Function
REQ-012 Handshake: a request SHALL be accepted on a posedge where press_req_i=1 and ready_o=1; press_len_i SHALL be captured on that edge; press_req_i while ready_o=0 SHALL be ignored.
REQ-013 FSM states SHALL be IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT; acceptance moves IDLE->BOUNCE_IN on the accepting edge.
REQ-014 ready_o SHALL equal 1 exactly in IDLE; key_o SHALL be 1 in IDLE.
REQ-015 A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle, including IDLE.
REQ-016 In BOUNCE_IN and BOUNCE_OUT, key_o SHALL equal LFSR bit 0, except that it SHALL be forced to 1 whenever it has already been 0 for GLITCH_TIME_CYCLES-1 consecutive cycles, so no bounce low-run reaches GLITCH_TIME_CYCLES.
REQ-017 Each bounce phase SHALL last exactly BOUNCE_CYCLES cycles, and its last cycle SHALL drive key_o=1.
REQ-018 HOLD SHALL drive key_o=0 for exactly press_len_i cycles, then enter BOUNCE_OUT; press_len_i=0 SHALL skip HOLD (BOUNCE_IN->BOUNCE_OUT directly).
REQ-019 Consequently the HOLD low-run SHALL be exactly press_len_i cycles, bounded by key_o=1 on both sides.
REQ-020 After BOUNCE_OUT the FSM SHALL return to IDLE and assert done_stb_o for exactly the first IDLE cycle.
REQ-021 A request presented in that first IDLE cycle SHALL be accepted (back-to-back sequences, one idle cycle minimum).
REQ-022 Phase and hold counters SHALL be sized from parameters with no wrap-around; press_len_i=16'hFFFF SHALL hold 65535 cycles.

Reset
REQ-023 Asserting rst_n_i SHALL immediately force key_o=1, done_stb_o=0, ready_o=1, FSM=IDLE, LFSR=LFSR_SEED, all counters 0.
REQ-024 Reset mid-sequence SHALL abort it without a done_stb_o pulse; first acceptance is possible on the first posedge after deassertion.

Configuration
REQ-025 Macro KEY_BOUNCE_GEN_RELEASE_BOUNCE_EN: defined, BOUNCE_OUT behaves per REQ-016/017; undefined, BOUNCE_OUT lasts exactly 1 cycle with key_o=1, so total sequence = BOUNCE_CYCLES + press_len_i + 1 cycles.

Verification
REQ-026 Reset release, no request, 100 cycles -> key_o=1, ready_o=1, done_stb_o=0 throughout.
REQ-027 Defaults, press_len_i=15 -> exactly one low-run of 15 cycles, all other low-runs <=14; done_stb_o once, 20+15+20 cycles after acceptance (macro defined); debouncer fed by key_o emits exactly one strobe.
REQ-028 press_len_i=14 -> no low-run >=15; attached debouncer emits no strobe; done_stb_o after 54 cycles.
REQ-029 press_len_i=0 -> HOLD skipped, done_stb_o 40 cycles after acceptance; press_req_i held high during busy -> no extra sequence.
REQ-030 rst_n_i pulsed low 5 cycles into HOLD -> key_o=1 same cycle, no done_stb_o, new request accepted on first edge after release.
REQ-031 Macro undefined, press_len_i=100 -> done_stb_o 121 cycles after acceptance, no low-run during release.

Source files
------------

// File: rtl/key_bounce_gen.sv
// Emulates a mechanical key press with pseudo-random contact bounce around a clean hold.
// Define KEY_BOUNCE_GEN_RELEASE_BOUNCE_EN to bounce on release as well as on press.
module key_bounce_gen #(
    parameter int          CLK_FREQ_MHZ   = 100,
    parameter int          GLITCH_TIME_NS = 150,
    parameter int          BOUNCE_CYCLES  = 20,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        press_req_i,
    input  logic [15:0] press_len_i,
    output logic        ready_o,
    output logic        key_o,
    output logic        done_stb_o
);

    localparam int GLITCH_TIME_CYCLES = (CLK_FREQ_MHZ * GLITCH_TIME_NS + 999) / 1000;
    localparam int PH_W = $clog2(BOUNCE_CYCLES + 1);
    localparam int LO_W = $clog2(GLITCH_TIME_CYCLES + 1);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(BOUNCE_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_PENULT = PH_W'(BOUNCE_CYCLES - 2);
    localparam logic [LO_W-1:0] LO_MAX    = LO_W'(GLITCH_TIME_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT} state_t;

    state_t          state;
    logic [PH_W-1:0] phase_cnt;
    logic [15:0]     hold_cnt;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_nxt;
    logic [LO_W-1:0] lo_run;
    logic [LO_W-1:0] run_now;
    logic            bounce_key;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [LO_W-1:0] sat_inc(input logic [LO_W-1:0] v);
        return (v >= LO_MAX) ? LO_MAX : LO_W'(v + 1'b1);
    endfunction

    // run_now: length of the low-run ending in the current cycle; a bounce may
    // only go low if that keeps the run below the debouncer's glitch window.
    always_comb begin
        lfsr_nxt   = lfsr_step(lfsr);
        run_now    = key_o ? '0 : sat_inc(lo_run);
        bounce_key = lfsr_nxt[0] | (run_now >= LO_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            hold_cnt   <= '0;
            lfsr       <= LFSR_SEED;
            lo_run     <= '0;
            key_o      <= 1'b1;
            ready_o    <= 1'b1;
            done_stb_o <= 1'b0;
        end else begin
            lfsr       <= lfsr_nxt;
            lo_run     <= run_now;
            done_stb_o <= 1'b0;
            case (state)
                IDLE: begin
                    key_o   <= 1'b1;
                    ready_o <= 1'b1;
                    if (press_req_i) begin
                        state     <= BOUNCE_IN;
                        ready_o   <= 1'b0;
                        hold_cnt  <= press_len_i;
                        phase_cnt <= '0;
                        key_o     <= (BOUNCE_CYCLES == 1) ? 1'b1 : bounce_key;
                    end
                end
                BOUNCE_IN: begin
                    if (phase_cnt == PH_LAST) begin
                        phase_cnt <= '0;
                        if (hold_cnt != 16'd0) begin
                            state <= HOLD;
                            key_o <= 1'b0;
                        end else begin
                            state <= BOUNCE_OUT;
                            key_o <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                        key_o     <= (phase_cnt == PH_PENULT) ? 1'b1 : bounce_key;
                    end
                end
                HOLD: begin
                    // First release cycle is high so the hold run is cleanly bounded.
                    if (hold_cnt == 16'd1) begin
                        state     <= BOUNCE_OUT;
                        phase_cnt <= '0;
                        key_o     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                        key_o    <= 1'b0;
                    end
                end
                BOUNCE_OUT: begin
`ifdef KEY_BOUNCE_GEN_RELEASE_BOUNCE_EN
                    if (phase_cnt == PH_LAST) begin
                        state      <= IDLE;
                        phase_cnt  <= '0;
                        ready_o    <= 1'b1;
                        done_stb_o <= 1'b1;
                        key_o      <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                        key_o     <= (phase_cnt == PH_PENULT) ? 1'b1 : bounce_key;
                    end
`else
                    state      <= IDLE;
                    phase_cnt  <= '0;
                    ready_o    <= 1'b1;
                    done_stb_o <= 1'b1;
                    key_o      <= 1'b1;
`endif
                end
                default: begin
                    state   <= IDLE;
                    key_o   <= 1'b1;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Scoreboard bench for key_bounce_gen: stimulus queues expected completions, a monitor checks them.
`timescale 1ns/1ps
module tb_key_bounce_gen;

    localparam int BC     = 20;
    localparam int GLITCH = 15;
`ifdef KEY_BOUNCE_GEN_RELEASE_BOUNCE_EN
    localparam int BO = 20;
`else
    localparam int BO = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        press_req = 1'b0;
    logic [15:0] press_len = 16'd0;
    logic        ready;
    logic        key;
    logic        done;

    key_bounce_gen dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .press_req_i (press_req),
        .press_len_i (press_len),
        .ready_o     (ready),
        .key_o       (key),
        .done_stb_o  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int done_cyc;
        int nlong;
        int len;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   npush = 0;
    int   ndone = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one request; 'now' presents it without waiting for a falling edge.
    task automatic do_req(input logic [15:0] len, input bit hold, input bit now);
        exp_t e;
        if (!now) @(negedge clk);
        check("ready_before_req", {31'd0, ready}, 32'd1);
        press_req = 1'b1;
        press_len = len;
        @(posedge clk);
        #1;
        e.done_cyc = cyc + BC + int'(len) + BO;
        e.nlong    = (int'(len) >= GLITCH) ? 1 : 0;
        e.len      = int'(len);
        q.push_back(e);
        npush++;
        @(negedge clk);
        check("ready_busy", {31'd0, ready}, 32'd0);
        if (!hold) press_req = 1'b0;
    endtask

    // Monitor: low-run statistics, debouncer model, scoreboard pop on done.
    initial begin
        int   run = 0;
        int   seq_long = 0;
        int   seq_max = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0; seq_long = 0; seq_max = 0;
            end else begin
                if (key === 1'b0) begin
                    run++;
                    if (run == GLITCH) seq_long++;
                    if (run > seq_max) seq_max = run;
                end else begin
                    run = 0;
                end
                if (done === 1'b1) begin
                    ndone++;
                    if (q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("done_cycle", cyc, e.done_cyc);
                        check("debounce_strobes", seq_long, e.nlong);
                        if (e.len >= GLITCH) check("hold_run_len", seq_max, e.len);
                    end
                    seq_long = 0;
                    seq_max  = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_key = 0;
        int bad_rdy = 0;
        int bad_done = 0;

        repeat (3) @(negedge clk);
        check("rst_key", {31'd0, key}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // Idle with no request.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key !== 1'b1) bad_key++;
            if (ready !== 1'b1) bad_rdy++;
            if (done !== 1'b0) bad_done++;
        end
        check("idle_key_bad_cycles", bad_key, 0);
        check("idle_ready_bad_cycles", bad_rdy, 0);
        check("idle_done_bad_cycles", bad_done, 0);

        // press_len 15, then 14 presented in the done cycle.
        do_req(16'd15, 1'b0, 1'b0);
        repeat (BC + 15 + BO) @(posedge clk);
        do_req(16'd14, 1'b0, 1'b0);
        repeat (BC + 14 + BO) @(posedge clk);
        repeat (3) @(negedge clk);

        // press_len 0 with the request held high while busy.
        do_req(16'd0, 1'b1, 1'b0);
        repeat (BC + BO - 1) @(posedge clk);
        @(negedge clk);
        check("ready_held_req", {31'd0, ready}, 32'd0);
        press_req = 1'b0;
        repeat (30) @(negedge clk);

        // Long hold.
        do_req(16'd100, 1'b0, 1'b0);
        repeat (BC + 100 + BO + 3) @(posedge clk);

        // Reset five cycles into HOLD.
        do_req(16'd50, 1'b0, 1'b0);
        npush--;
        void'(q.pop_back());
        repeat (BC + 4) @(posedge clk);
        @(negedge clk);
        check("abort_key_in_hold", {31'd0, key}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_key", {31'd0, key}, 32'd1);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        do_req(16'd3, 1'b0, 1'b1);
        repeat (BC + 3 + BO + 5) @(posedge clk);

        @(negedge clk);
        check("queue_empty", q.size(), 0);
        check("done_count", ndone, npush);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
